// File: rtl/led_blink_multi.sv
// rtl/led_blink_multi.sv - multi-channel LED driver with OFF/ON/BLINK/PWM modes
// Shared prescaler tick and PWM counter; per-channel config written one channel per cycle.
module led_blink_multi #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 32,
    parameter int TICK_DIV = 100000,
    parameter int PWM_W    = 8
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [1:0]                                     cfg_mode,
    input  logic [CNT_W-1:0]                               cfg_period,
    input  logic [PWM_W-1:0]                               cfg_duty,
    output logic [NUM_CH-1:0]                              led,
    output logic                                           tick
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } mode_t;

    logic [PRE_W-1:0] pre;
    logic [PWM_W-1:0] pwm_cnt;
    mode_t            mode   [NUM_CH];
    logic [CNT_W-1:0] period [NUM_CH];
    logic [CNT_W-1:0] cnt    [NUM_CH];
    logic [PWM_W-1:0] duty   [NUM_CH];
    logic [NUM_CH-1:0] blink;

    // Gated by rst_n so no tick is seen while reset is held.
    assign tick = (pre == PRE_LAST) && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre     <= '0;
            pwm_cnt <= '0;
        end else begin
            pre     <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!rst_n) begin
                mode[i]   <= MODE_OFF;
                period[i] <= '0;
                duty[i]   <= '0;
                cnt[i]    <= '0;
                blink[i]  <= 1'b0;
                led[i]    <= 1'b0;
            end else begin
                // A write on the same edge as a tick restarts the channel without toggling.
                if (cfg_we && (cfg_ch == CH_W'(i))) begin
                    mode[i]   <= mode_t'(cfg_mode);
                    period[i] <= cfg_period;
                    duty[i]   <= cfg_duty;
                    cnt[i]    <= '0;
                    blink[i]  <= 1'b0;
                end else if (mode[i] != MODE_BLINK) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    if (cnt[i] == ((period[i] == '0) ? '0 : period[i] - CNT_W'(1))) begin
                        cnt[i]   <= '0;
                        blink[i] <= ~blink[i];
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end

                case (mode[i])
                    MODE_OFF:   led[i] <= 1'b0;
                    MODE_ON:    led[i] <= 1'b1;
                    MODE_BLINK: led[i] <= blink[i];
                    MODE_PWM:   led[i] <= (pwm_cnt < duty[i]);
                    default:    led[i] <= 1'b0;
                endcase
            end
        end
    end
endmodule
